uncache_axi_bridge: RTL and testbench
=====================================

Name: uncache_axi_bridge

Overview:
Bus-side responder for the CPU's uncached-access path. It captures a single uncached load/store request from the memory stage and performs it as one single-beat AXI4-lite-style transfer. It returns read data and pulses `refresh` so the stalled tag logic can release its stall. It sits between the memory stage/uncache tag and the SoC bus crossbar.

Parameters:
ADDR_W, 64, request/bus address width
DATA_W, 64, data width; byte strobe width is DATA_W/8

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low (`RstEnable` = 1'b0); reset taken when rst==0 at posedge clk
sram_e  in  1  uncached request valid (level, held while CPU stalled)
sram_we  in  1  1=store, 0=load
sram_sel  in  8  byte enables of the access
sram_addr  in  ADDR_W  access address
sram_wdata  in  DATA_W  store data
refresh  out  1  one-cycle pulse: transfer complete
rdata  out  DATA_W  load data, valid from refresh pulse until next capture
bus_err  out  1  sticky-per-transfer: last response was not OKAY
araddr  out  ADDR_W  read address
arsize  out  3  log2 bytes
arvalid  out  1
arready  in  1
rdata_i  in  DATA_W  bus read data
rresp  in  2
rvalid  in  1
rready  out  1
awaddr  out  ADDR_W
awsize  out  3
awvalid  out  1
awready  in  1
wdata  out  DATA_W
wstrb  out  8
wvalid  out  1
wready  in  1
bresp  in  2
bvalid  in  1
bready  out  1

Behaviour:
- Reset values: all valid/ready outputs 0, refresh 0, rdata 0, bus_err 0, state IDLE.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE: if sram_e=1, latch addr/we/sel/wdata next edge.
  - Load: go to RD_ADDR with arvalid=1.
  - Store: go to WR_REQ with awvalid=wvalid=1.
  - Requests arriving in any other state are ignored; they are held by the stalled CPU.
- Size from sel:
  - Single bit set → 0.
  - Two contiguous bits → 1.
  - Four contiguous bits → 2.
  - 0xFF → 3.
  - Anything else → 3.
  - wstrb = latched sel. Addresses are passed unmodified.
- RD_ADDR: hold arvalid/araddr stable until arvalid&arready; then arvalid=0, rready=1, go to RD_DATA.
- RD_DATA: on rvalid&rready, rdata←rdata_i, bus_err←(rresp!=0), rready=0, go to DONE.
- WR_REQ: AW and W handshake independently.
  - Each valid drops the cycle after its own handshake.
  - Both handshakes may occur in the same cycle, or in either order.
  - When both are done, bready=1 and go to WR_RESP.
- WR_RESP: on bvalid&bready, bus_err←(bresp!=0), bready=0, go to DONE. rdata is unchanged on stores.
- DONE: refresh=1 for exactly one cycle, then IDLE.
- Minimum latency: capture→refresh is 4 cycles for a load and 4 cycles for a store with zero-wait slave. Each slave wait cycle adds one.
- Re-capture: the earliest next capture is the cycle after DONE. The CPU must deassert or change sram_e upon refresh. If sram_e is still high in IDLE, it is treated as a new request.
- Valid signals never drop without a handshake, except on reset.
- Reset mid-transfer: outstanding valids drop on the next edge. The bus slave shares the reset, so no response is awaited.
- bus_err is updated at each completion and held until the next completion.

Decomposition:
- Shared defines header: `RstEnable`, state encodings (`UB_IDLE`..`UB_DONE`), and AXI resp codes (`RESP_OKAY`=2'b00).
- One natural sub-module: uncache_size_enc, a combinational sel→size encoder.

Test Plan:
1. Load addr 0x1000_0000, sel 0x0F, slave 0-wait rdata_i=0xDEAD_BEEF, rresp 0:
   - arsize=2.
   - refresh pulses 4 cycles after capture.
   - rdata=0x...DEADBEEF, bus_err=0.
2. Store addr 0x1000_0008, sel 0x01, wdata 0x5A, awready arrives 3 cycles after wready:
   - wvalid drops after its handshake while awvalid stays high.
   - wstrb=0x01, awsize=0.
   - One refresh pulse after bvalid.
3. Load with arready delayed 5 cycles and rresp=2'b10:
   - araddr stable throughout the wait.
   - refresh once, bus_err=1.
   - A subsequent OKAY store clears bus_err to 0.
4. sram_e held high through DONE:
   - A second transfer starts exactly one cycle after refresh.
   - No double refresh within a transfer.
5. Assert rst=0 while in RD_DATA:
   - All valid/ready outputs and refresh go to 0 next edge, state IDLE.
   - After release, a new load completes normally.
6. AW and W handshakes in the same cycle with bvalid held 2 cycles: WR_RESP is entered once and exactly one completion occurs.

Source files
------------

// File: rtl/uncache_axi_bridge_pkg.sv
// -----------------------------------------------------------------------------
// uncache_axi_bridge_pkg
// Shared definitions for the uncached-access bus bridge:
//   RstEnable  - reset level of the bridge reset input (active-low)
//   RESP_OKAY  - AXI response code for a successful transfer
//   SIZE_W     - width of the AXI size fields
//   ub_state_e - bridge state encoding (UB_IDLE .. UB_DONE)
// -----------------------------------------------------------------------------
package uncache_axi_bridge_pkg;

    localparam logic       RstEnable = 1'b0;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam int         SIZE_W    = 3;

    typedef enum logic [2:0] {
        UB_IDLE    = 3'd0,
        UB_RD_ADDR = 3'd1,
        UB_RD_DATA = 3'd2,
        UB_WR_REQ  = 3'd3,
        UB_WR_RESP = 3'd4,
        UB_DONE    = 3'd5
    } ub_state_e;

endpackage

// File: rtl/uncache_axi_bridge_size_enc.sv
// -----------------------------------------------------------------------------
// uncache_axi_bridge_size_enc
// Combinational byte-enable to AXI size encoder.
//   sel_i  [STRB_W]  byte enables of the access
//   size_o [SIZE_W]  log2 of the access width in bytes
// One byte -> 0, two contiguous bytes -> 1, four contiguous bytes -> 2.
// Every other pattern (full width, sparse, empty) is issued as a full-width
// access and the strobes select the bytes.
// -----------------------------------------------------------------------------
module uncache_axi_bridge_size_enc
    import uncache_axi_bridge_pkg::*;
#(
    parameter int STRB_W = 8
) (
    input  logic [STRB_W-1:0] sel_i,
    output logic [SIZE_W-1:0] size_o
);

    always_comb begin
        size_o = SIZE_W'(3);
        for (int i = 0; i < STRB_W; i++) begin
            if (sel_i == (STRB_W'(1) << i)) begin
                size_o = SIZE_W'(0);
            end
            // The bound check keeps a shifted pattern from being truncated
            // into a narrower one at the top of the word.
            if ((i + 1 < STRB_W) && (sel_i == (STRB_W'(3) << i))) begin
                size_o = SIZE_W'(1);
            end
            if ((i + 3 < STRB_W) && (sel_i == (STRB_W'(15) << i))) begin
                size_o = SIZE_W'(2);
            end
        end
    end

endmodule

// File: rtl/uncache_axi_bridge.sv
// -----------------------------------------------------------------------------
// uncache_axi_bridge
// Performs one uncached load/store from the memory stage as a single-beat
// AXI4-lite-style transfer and pulses refresh when it completes.
//   clk, rst                 clock, synchronous active-low reset
//   sram_e/we/sel/addr/wdata uncached request from the stalled CPU
//   refresh                  one-cycle completion pulse
//   rdata, bus_err           load data / non-OKAY flag of last completion
//   ar*/r*                   read address and read data channels
//   aw*/w*/b*                write address, write data and response channels
// -----------------------------------------------------------------------------
module uncache_axi_bridge
    import uncache_axi_bridge_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sram_e,
    input  logic                sram_we,
    input  logic [DATA_W/8-1:0] sram_sel,
    input  logic [ADDR_W-1:0]   sram_addr,
    input  logic [DATA_W-1:0]   sram_wdata,
    output logic                refresh,
    output logic [DATA_W-1:0]   rdata,
    output logic                bus_err,
    output logic [ADDR_W-1:0]   araddr,
    output logic [SIZE_W-1:0]   arsize,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata_i,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [SIZE_W-1:0]   awsize,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);

    localparam int STRB_W = DATA_W / 8;

    ub_state_e           state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [STRB_W-1:0]   sel_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [SIZE_W-1:0]   size_d;
    logic [SIZE_W-1:0]   size_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                bus_err_q;
    logic                refresh_q;
    logic                arvalid_q;
    logic                rready_q;
    logic                awvalid_q;
    logic                wvalid_q;
    logic                bready_q;

    // Size is encoded from the live request and latched with it.
    uncache_axi_bridge_size_enc #(
        .STRB_W (STRB_W)
    ) u_size_enc (
        .sel_i  (sram_sel),
        .size_o (size_d)
    );

    // A write channel counts as finished once its valid has already dropped
    // or it handshakes this cycle; this lets AW and W complete in any order.
    logic aw_fin;
    logic w_fin;
    assign aw_fin = !awvalid_q || awready;
    assign w_fin  = !wvalid_q  || wready;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q   <= UB_IDLE;
            addr_q    <= '0;
            sel_q     <= '0;
            wdata_q   <= '0;
            size_q    <= '0;
            rdata_q   <= '0;
            bus_err_q <= 1'b0;
            refresh_q <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            refresh_q <= 1'b0;
            case (state_q)
                UB_IDLE: begin
                    if (sram_e) begin
                        addr_q  <= sram_addr;
                        sel_q   <= sram_sel;
                        wdata_q <= sram_wdata;
                        size_q  <= size_d;
                        if (sram_we) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= UB_WR_REQ;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= UB_RD_ADDR;
                        end
                    end
                end
                UB_RD_ADDR: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= UB_RD_DATA;
                    end
                end
                UB_RD_DATA: begin
                    if (rvalid) begin
                        rdata_q   <= rdata_i;
                        bus_err_q <= (rresp != RESP_OKAY);
                        rready_q  <= 1'b0;
                        state_q   <= UB_DONE;
                    end
                end
                UB_WR_REQ: begin
                    if (awready) awvalid_q <= 1'b0;
                    if (wready)  wvalid_q  <= 1'b0;
                    if (aw_fin && w_fin) begin
                        bready_q <= 1'b1;
                        state_q  <= UB_WR_RESP;
                    end
                end
                UB_WR_RESP: begin
                    if (bvalid) begin
                        bus_err_q <= (bresp != RESP_OKAY);
                        bready_q  <= 1'b0;
                        state_q   <= UB_DONE;
                    end
                end
                UB_DONE: begin
                    // Pulse lands in the following IDLE cycle, so a request
                    // still held high is recaptured right after refresh.
                    refresh_q <= 1'b1;
                    state_q   <= UB_IDLE;
                end
                default: state_q <= UB_IDLE;
            endcase
        end
    end

    assign refresh = refresh_q;
    assign rdata   = rdata_q;
    assign bus_err = bus_err_q;
    assign araddr  = addr_q;
    assign arsize  = size_q;
    assign arvalid = arvalid_q;
    assign rready  = rready_q;
    assign awaddr  = addr_q;
    assign awsize  = size_q;
    assign awvalid = awvalid_q;
    assign wdata   = wdata_q;
    assign wstrb   = sel_q;
    assign wvalid  = wvalid_q;
    assign bready  = bready_q;

endmodule

// File: tb/tb_uncache_axi_bridge.sv
module tb_uncache_axi_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sram_e = 1'b0;
    logic        sram_we = 1'b0;
    logic [7:0]  sram_sel = '0;
    logic [63:0] sram_addr = '0;
    logic [63:0] sram_wdata = '0;
    logic        refresh;
    logic [63:0] rdata;
    logic        bus_err;
    logic [63:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [63:0] rdata_i;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [63:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    uncache_axi_bridge #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .rst(rst),
        .sram_e(sram_e), .sram_we(sram_we), .sram_sel(sram_sel),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .refresh(refresh), .rdata(rdata), .bus_err(bus_err),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata_i(rdata_i), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Slave behaviour knobs
    int          ar_delay = 0;
    int          aw_delay = 0;
    int          w_delay  = 0;
    int          b_hold   = 1;
    logic        r_en     = 1'b1;
    logic [63:0] slv_rdata = '0;
    logic [1:0]  slv_rresp = 2'b00;
    logic [1:0]  slv_bresp = 2'b00;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;
    exp_t        exp_q[$];
    logic [63:0] model_rdata = '0;

    logic snap_aw [0:31];
    logic snap_w  [0:31];
    int   n_bready;

    // AXI slave model: all responses are driven on the falling edge.
    initial begin : slave
        int ar_cnt, aw_cnt, w_cnt, b_cnt;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        arready = 0; awready = 0; wready = 0;
        rvalid = 0; rdata_i = '0; rresp = 2'b00;
        bvalid = 0; bresp = 2'b00;
        forever begin
            @(negedge clk);
            if (!arvalid) begin ar_cnt = 0; arready = 0; end
            else if (ar_cnt >= ar_delay) arready = 1;
            else begin arready = 0; ar_cnt++; end
            if (!awvalid) begin aw_cnt = 0; awready = 0; end
            else if (aw_cnt >= aw_delay) awready = 1;
            else begin awready = 0; aw_cnt++; end
            if (!wvalid) begin w_cnt = 0; wready = 0; end
            else if (w_cnt >= w_delay) wready = 1;
            else begin wready = 0; w_cnt++; end
            if (rready && r_en) begin
                rvalid = 1; rdata_i = slv_rdata; rresp = slv_rresp;
            end else begin
                rvalid = 0;
            end
            if (bready && b_cnt == 0) b_cnt = b_hold;
            if (b_cnt > 0) begin bvalid = 1; bresp = slv_bresp; b_cnt--; end
            else bvalid = 0;
        end
    end

    // Runs one request; checks first-cycle channel values, address stability,
    // refresh count and latency, and scoreboard data at refresh.
    task automatic do_xfer(input logic we, input logic [63:0] addr, input logic [7:0] sel,
                           input logic [63:0] wd, input logic [2:0] exp_size,
                           input int exp_lat, input string name);
        exp_t e;
        exp_t got;
        int   n_ref = 0;
        int   ref_at = -1;
        logic addr_ok = 1'b1;
        e.rdata = we ? model_rdata : slv_rdata;
        e.err   = we ? (slv_bresp != 2'b00) : (slv_rresp != 2'b00);
        model_rdata = e.rdata;
        exp_q.push_back(e);
        n_bready = 0;
        @(negedge clk);
        sram_e = 1; sram_we = we; sram_addr = addr; sram_sel = sel; sram_wdata = wd;
        for (int k = 1; k <= exp_lat + 3; k++) begin
            @(negedge clk);
            snap_aw[k] = awvalid;
            snap_w[k]  = wvalid;
            if (k == 1) begin
                vectors++;
                if (we) begin
                    if ({awvalid, wvalid, awsize, wstrb, wdata} !== {2'b11, exp_size, sel, wd}) begin
                        miscompares++;
                        $display("FAIL %s_wr_req: got aw/w valid=%b%b size=%0d strb=%h data=%h, want 11 size=%0d strb=%h data=%h",
                                 name, awvalid, wvalid, awsize, wstrb, wdata, exp_size, sel, wd);
                    end
                end else begin
                    if ({arvalid, arsize} !== {1'b1, exp_size}) begin
                        miscompares++;
                        $display("FAIL %s_rd_addr: got arvalid=%b arsize=%0d, want 1 arsize=%0d",
                                 name, arvalid, arsize, exp_size);
                    end
                end
            end
            if (arvalid && araddr !== addr) addr_ok = 1'b0;
            if (awvalid && awaddr !== addr) addr_ok = 1'b0;
            if (bready) n_bready++;
            if (refresh) begin
                n_ref++;
                if (ref_at < 0) ref_at = k;
                sram_e = 0;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL %s_scoreboard: got refresh, want no completion pending", name);
                end else begin
                    got = exp_q.pop_front();
                    if (rdata !== got.rdata || bus_err !== got.err) begin
                        miscompares++;
                        $display("FAIL %s_result: got rdata=%h bus_err=%b, want rdata=%h bus_err=%b",
                                 name, rdata, bus_err, got.rdata, got.err);
                    end
                end
            end
        end
        sram_e = 0;
        vectors++;
        if (n_ref != 1 || ref_at != exp_lat) begin
            miscompares++;
            $display("FAIL %s_refresh: got %0d pulses first at cycle %0d, want 1 at cycle %0d",
                     name, n_ref, ref_at, exp_lat);
            exp_q.delete();
        end
        vectors++;
        if (!addr_ok) begin
            miscompares++;
            $display("FAIL %s_addr: got unstable or wrong address, want %h held", name, addr);
        end
        $display("xfer %s: we=%b addr=%h sel=%h rdata=%h bus_err=%b refresh@%0d", name, we, addr, sel,
                 rdata, bus_err, ref_at);
    endtask

    task automatic test_reset();
        rst = 0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({arvalid, rready, awvalid, wvalid, bready, refresh, bus_err} !== 7'b0 || rdata !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got ar=%b r=%b aw=%b w=%b b=%b ref=%b err=%b rdata=%h, want all 0",
                     arvalid, rready, awvalid, wvalid, bready, refresh, bus_err, rdata);
        end
        rst = 1;
        $display("reset: outputs idle");
    endtask

    task automatic test_load_basic();
        ar_delay = 0; slv_rdata = 64'h0000_0000_DEAD_BEEF; slv_rresp = 2'b00;
        do_xfer(1'b0, 64'h1000_0000, 8'h0F, 64'd0, 3'd2, 4, "load_basic");
    endtask

    task automatic test_store_split();
        aw_delay = 3; w_delay = 0; slv_bresp = 2'b00;
        do_xfer(1'b1, 64'h1000_0008, 8'h01, 64'h5A, 3'd0, 7, "store_split");
        vectors++;
        if (snap_w[2] !== 1'b0 || snap_aw[2] !== 1'b1) begin
            miscompares++;
            $display("FAIL store_split_valids: got wvalid=%b awvalid=%b after W handshake, want 0 1",
                     snap_w[2], snap_aw[2]);
        end
        aw_delay = 0;
    endtask

    task automatic test_load_error();
        ar_delay = 5; slv_rdata = 64'h0123_4567_89AB_CDEF; slv_rresp = 2'b10;
        do_xfer(1'b0, 64'h2000_0010, 8'h03, 64'd0, 3'd1, 9, "load_err");
        ar_delay = 0; slv_rresp = 2'b00; slv_bresp = 2'b00;
        do_xfer(1'b1, 64'h2000_0020, 8'hFF, 64'h1122_3344_5566_7788, 3'd3, 4, "store_ok");
    endtask

    task automatic test_back_to_back();
        exp_t e;
        exp_t got;
        int   n_ref = 0;
        int   ref1 = -1;
        int   ref2 = -1;
        logic ar5 = 1'b0;
        slv_rdata = 64'hCAFE_F00D_0000_0042; slv_rresp = 2'b00; ar_delay = 0;
        e.rdata = slv_rdata; e.err = 1'b0; model_rdata = slv_rdata;
        exp_q.push_back(e);
        exp_q.push_back(e);
        @(negedge clk);
        sram_e = 1; sram_we = 0; sram_addr = 64'h3000_0000; sram_sel = 8'hF0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 5) ar5 = arvalid;
            if (refresh) begin
                n_ref++;
                if (n_ref == 1) ref1 = k;
                if (n_ref == 2) begin ref2 = k; sram_e = 0; end
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL b2b_scoreboard: got extra refresh at cycle %0d, want none", k);
                end else begin
                    got = exp_q.pop_front();
                    if (rdata !== got.rdata || bus_err !== got.err) begin
                        miscompares++;
                        $display("FAIL b2b_result: got rdata=%h bus_err=%b, want %h %b",
                                 rdata, bus_err, got.rdata, got.err);
                    end
                end
            end
        end
        sram_e = 0;
        vectors++;
        if (n_ref != 2 || ref1 != 4 || ref2 != 8 || ar5 !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_timing: got %0d pulses at %0d,%0d arvalid@5=%b, want 2 at 4,8 arvalid@5=1",
                     n_ref, ref1, ref2, ar5);
            exp_q.delete();
        end
        $display("xfer b2b: two loads refresh@%0d,%0d", ref1, ref2);
    endtask

    task automatic test_reset_mid();
        r_en = 0; ar_delay = 0;
        @(negedge clk);
        sram_e = 1; sram_we = 0; sram_addr = 64'h4000_0000; sram_sel = 8'h01;
        repeat (2) @(negedge clk);
        vectors++;
        if (rready !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_setup: got rready=%b, want 1", rready);
        end
        rst = 0; sram_e = 0;
        @(negedge clk);
        vectors++;
        if ({arvalid, rready, awvalid, wvalid, bready, refresh, bus_err} !== 7'b0 || rdata !== 64'd0) begin
            miscompares++;
            $display("FAIL rstmid_outputs: got ar=%b r=%b aw=%b w=%b b=%b ref=%b err=%b rdata=%h, want all 0",
                     arvalid, rready, awvalid, wvalid, bready, refresh, bus_err, rdata);
        end
        rst = 1; r_en = 1; model_rdata = 64'd0;
        slv_rdata = 64'h0000_0000_0000_00A5; slv_rresp = 2'b00;
        do_xfer(1'b0, 64'h4000_0000, 8'h01, 64'd0, 3'd0, 4, "load_after_rst");
    endtask

    task automatic test_write_same_cycle();
        aw_delay = 0; w_delay = 0; b_hold = 2; slv_bresp = 2'b00;
        do_xfer(1'b1, 64'h5000_0004, 8'h0C, 64'h0000_0000_BEEF_0000, 3'd1, 4, "store_same");
        vectors++;
        if (n_bready != 1) begin
            miscompares++;
            $display("FAIL store_same_bready: got %0d bready cycles, want 1", n_bready);
        end
        b_hold = 1;
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_store_split();
        test_load_error();
        test_back_to_back();
        test_reset_mid();
        test_write_same_cycle();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, want finish within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
